// File: rtl/axi_config_regfile.sv
// Config register bank: NUM_CTRL RW control words, sticky STATUS with IRQ_EN mask, RO ID word.
// Define AXI_CONFIG_REGFILE_CLR_ON_READ_EN to make STATUS clear-on-read instead of W1C.
module axi_config_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_CTRL = 8,
  parameter int NUM_STAT = 16,
  parameter int RD_LATENCY = 1,
  parameter logic [31:0] ID_VALUE = 32'h0001_0000,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic                           wr,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_q,
  input  logic [NUM_STAT-1:0]            stat_evt,
  output logic                           irq
);

  // Handshake: rd and wr are single-cycle strobes that are always accepted (no ready);
  // rvalid is a one-cycle pulse RD_LATENCY cycles after rd, rdata is valid only with it.

  localparam int SHIFT = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] IDX_STAT  = ADDR_WIDTH'(NUM_CTRL);
  localparam logic [ADDR_WIDTH-1:0] IDX_IRQEN = ADDR_WIDTH'(NUM_CTRL + 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ID    = ADDR_WIDTH'(NUM_CTRL + 2);

  logic [ADDR_WIDTH-1:0] ridx;
  logic [ADDR_WIDTH-1:0] widx;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] ctrl [NUM_CTRL];
  logic [NUM_STAT-1:0]   status;
  logic [NUM_STAT-1:0]   irq_en;
  logic [NUM_STAT-1:0]   stat_clr;
  logic [DATA_WIDTH-1:0] stat_ext;
  logic [DATA_WIDTH-1:0] irqen_ext;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_v;

  assign ridx = raddr >> SHIFT;
  assign widx = waddr >> SHIFT;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      wmask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  always_comb begin
    ctrl_q = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_q[i*DATA_WIDTH +: DATA_WIDTH] = ctrl[i];
    end
  end

  // Bits to drop from STATUS this cycle; a same-cycle event is OR-ed back in afterwards.
  always_comb begin
    stat_clr = '0;
`ifdef AXI_CONFIG_REGFILE_CLR_ON_READ_EN
    if (rd && ridx == IDX_STAT) stat_clr = status;
`else
    if (wr && widx == IDX_STAT) stat_clr = wdata[NUM_STAT-1:0] & wmask[NUM_STAT-1:0];
`endif
  end

  always_comb begin
    stat_ext = '0;
    irqen_ext = '0;
    stat_ext[NUM_STAT-1:0] = status;
    irqen_ext[NUM_STAT-1:0] = irq_en;
  end

  // Read mux sees pre-write register state, giving read-before-write on collisions.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (ridx == ADDR_WIDTH'(i)) rd_word = ctrl[i];
    end
    if (ridx == IDX_STAT)  rd_word = stat_ext;
    if (ridx == IDX_IRQEN) rd_word = irqen_ext;
    if (ridx == IDX_ID)    rd_word = DATA_WIDTH'(ID_VALUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl[i] <= CTRL_RESET;
      status <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (wr && widx == ADDR_WIDTH'(i)) ctrl[i] <= (ctrl[i] & ~wmask) | (wdata & wmask);
      end
      if (wr && widx == IDX_IRQEN)
        irq_en <= (irq_en & ~wmask[NUM_STAT-1:0]) | (wdata[NUM_STAT-1:0] & wmask[NUM_STAT-1:0]);
      status <= (status & ~stat_clr) | stat_evt;
      irq    <= |(status & irq_en);
    end
  end

  // Each stage only loads when its input is valid, so rdata holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd;
      if (rd) pipe_d[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign rdata  = pipe_d[RD_LATENCY-1];
  assign rvalid = pipe_v[RD_LATENCY-1];

endmodule

// File: tb/tb_axi_config_regfile.sv
// Bench for axi_config_regfile: a RD_LATENCY=1 instance driven from a vector table plus
// hand sequences, and a RD_LATENCY=3 instance for pipelined reads and reset flush.
module tb_axi_config_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 8;
  localparam int NS = 16;

  logic          clk;
  logic          rst, rst_b;
  logic          rd, rd_b;
  logic [AW-1:0] raddr, raddr_b;
  logic [DW-1:0] rdata, rdata_b;
  logic          rvalid, rvalid_b;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [NC*DW-1:0] ctrl_q, ctrl_q_b;
  logic [NS-1:0] stat_evt;
  logic          irq, irq_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [$];

  axi_config_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CTRL(NC), .NUM_STAT(NS),
                       .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .rd(rd), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .ctrl_q(ctrl_q),
    .stat_evt(stat_evt), .irq(irq));

  axi_config_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CTRL(NC), .NUM_STAT(NS),
                       .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst_b), .rd(rd_b), .raddr(raddr_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .ctrl_q(ctrl_q_b),
    .stat_evt(stat_evt), .irq(irq_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    wr = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick();
    wr = 1'b0; wstrb = 4'h0;
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd = 1'b1; raddr = a;
    tick();
    rd = 1'b0;
    check({name, " rvalid"}, {31'd0, rvalid}, 32'd1);
    check({name, " rdata"}, rdata, exp);
    tick();
    check({name, " rvalid_drop"}, {31'd0, rvalid}, 32'd0);
    check({name, " rdata_hold"}, rdata, exp);
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    string         name;
  } vec_t;

  vec_t vecs [24];

  initial begin
    int t;
    logic [DW-1:0] got;

    rst = 1'b1; rst_b = 1'b1; rd = 1'b0; rd_b = 1'b0; raddr = '0; raddr_b = '0;
    wr = 1'b0; waddr = '0; wdata = '0; wstrb = '0; stat_evt = '0;
    repeat (3) tick();
    rst = 1'b0; rst_b = 1'b0;
    check("rst rvalid", {31'd0, rvalid}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst irq", {31'd0, irq}, 32'd0);
    check("rst ctrl_q w0", ctrl_q[0 +: DW], 32'd0);
    check("rst ctrl_q w7", ctrl_q[7*DW +: DW], 32'd0);
    check("rst rvalid_b", {31'd0, rvalid_b}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      vecs[i] = '{1'b0, AW'(i * 4), (i == 10) ? 32'h0001_0000 : 32'h0, 4'h0,
                  $sformatf("rd_idx%0d", i)};
    end
    vecs[12] = '{1'b1, 32'h08, 32'hAABBCCDD, 4'b1111, "wr_ctrl2_full"};
    vecs[13] = '{1'b1, 32'h08, 32'h11223344, 4'b0101, "wr_ctrl2_part"};
    vecs[14] = '{1'b0, 32'h08, 32'hAA22CC44, 4'h0,    "rd_ctrl2"};
    vecs[15] = '{1'b1, 32'h28, 32'hDEADBEEF, 4'b1111, "wr_id"};
    vecs[16] = '{1'b0, 32'h28, 32'h0001_0000, 4'h0,   "rd_id"};
    vecs[17] = '{1'b1, 32'h2C, 32'hCAFEF00D, 4'b1111, "wr_unmapped"};
    vecs[18] = '{1'b0, 32'h2C, 32'h0,        4'h0,    "rd_unmapped"};
    vecs[19] = '{1'b1, 32'h1F, 32'h12345678, 4'b1111, "wr_ctrl7_lowbits"};
    vecs[20] = '{1'b0, 32'h1C, 32'h12345678, 4'h0,    "rd_ctrl7"};
    vecs[21] = '{1'b1, 32'h24, 32'hFFFFFFFF, 4'b1111, "wr_irqen_all"};
    vecs[22] = '{1'b0, 32'h24, 32'h0000FFFF, 4'h0,    "rd_irqen_trunc"};
    vecs[23] = '{1'b1, 32'h24, 32'h0,        4'b1111, "wr_irqen_zero"};

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else do_read(vecs[i].name, vecs[i].addr, vecs[i].data);
    end
    check("ctrl_q w2", ctrl_q[2*DW +: DW], 32'hAA22CC44);
    check("ctrl_q w7", ctrl_q[7*DW +: DW], 32'h12345678);

    // status event with interrupt masked, then enabled
    stat_evt = 16'h0008;
    tick();
    stat_evt = '0;
    tick();
    check("irq masked", {31'd0, irq}, 32'd0);
    do_write(32'h24, 32'h8, 4'b1111);
    check("irq +1 after irqen wr", {31'd0, irq}, 32'd0);
    tick();
    check("irq +2 after irqen wr", {31'd0, irq}, 32'd1);

`ifdef AXI_CONFIG_REGFILE_CLR_ON_READ_EN
    do_read("cor rd_bit3", 32'h20, 32'h8);
    check("cor irq falls", {31'd0, irq}, 32'd0);
    stat_evt = 16'h0003;
    tick();
    stat_evt = '0;
    do_read("cor rd_3", 32'h20, 32'h3);
    do_read("cor rd_cleared", 32'h20, 32'h0);
    stat_evt = 16'h0001;
    tick();
    stat_evt = '0;
    do_write(32'h20, 32'h1, 4'b1111);
    do_read("cor w1c_ignored", 32'h20, 32'h1);
    stat_evt = 16'h0020;
    tick();
    do_read("cor evt_during_clr", 32'h20, 32'h20);
    stat_evt = '0;
    do_read("cor evt_kept", 32'h20, 32'h20);
`else
    do_read("rd_status_8", 32'h20, 32'h8);
    do_write(32'h20, 32'h8, 4'b0010);
    do_read("w1c_strb_off", 32'h20, 32'h8);
    do_write(32'h20, 32'h0, 4'b1111);
    do_read("w0_no_effect", 32'h20, 32'h8);
    do_write(32'h20, 32'h8, 4'b1111);
    check("irq +1 after w1c", {31'd0, irq}, 32'd1);
    tick();
    check("irq +2 after w1c", {31'd0, irq}, 32'd0);
    do_read("rd_status_clr", 32'h20, 32'h0);
    stat_evt = 16'h0020;
    tick();
    wr = 1'b1; waddr = 32'h20; wdata = 32'h20; wstrb = 4'b1111;
    tick();
    wr = 1'b0; wstrb = 4'h0; stat_evt = '0;
    do_read("set_beats_w1c", 32'h20, 32'h20);
    do_write(32'h20, 32'h20, 4'b1111);
    do_read("w1c_bit5", 32'h20, 32'h0);
`endif

    // pipelined reads on the latency-3 instance
    do_write(32'h00, 32'h100, 4'b1111);
    do_write(32'h04, 32'h101, 4'b1111);
    do_write(32'h0C, 32'h103, 4'b1111);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h101);
    exp_q.push_back(32'hAA22CC44);
    exp_q.push_back(32'h103);
    for (t = 1; t <= 10; t++) begin
      rd_b = (t <= 4);
      raddr_b = AW'((t - 1) * 4);
      tick();
      check($sformatf("lat3 rvalid t%0d", t), {31'd0, rvalid_b}, {31'd0, (t >= 3 && t <= 6)});
      if (rvalid_b) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        check($sformatf("lat3 rdata t%0d", t), rdata_b, got);
      end
    end
    rd_b = 1'b0;
    check("lat3 all returned", 32'(exp_q.size()), 32'd0);
    check("lat3 rdata_hold", rdata_b, 32'h103);

    // reset while reads are in flight: nothing may come out afterwards
    for (t = 1; t <= 10; t++) begin
      rd_b = (t <= 4);
      raddr_b = AW'((t - 1) * 4);
      rst_b = (t == 3 || t == 4);
      tick();
      check($sformatf("flush rvalid t%0d", t), {31'd0, rvalid_b}, 32'd0);
    end
    rd_b = 1'b0;
    check("flush rdata", rdata_b, 32'd0);
    check("flush ctrl_q w0", ctrl_q_b[0 +: DW], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_config_regfile.md
Name: axi_config_regfile

Overview:
- Register bank sitting directly downstream of the AXI4-to-config bridge.
- Consumes the bridge's simple rd/raddr and wr/waddr/wdata/wstrb strobes and returns rdata/rvalid.
- Holds NUM_CTRL read/write control words, one sticky status word with interrupt mask, and a read-only ID word.
- Drives the control words and a level interrupt out to the datapath.

Parameters:
- ADDR_WIDTH, 32, width of raddr/waddr in bits (byte address).
- DATA_WIDTH, 32, register width; must be 32 or 64.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- NUM_CTRL, 8, number of control registers, 1..64.
- NUM_STAT, 16, number of status event bits, 1..DATA_WIDTH.
- RD_LATENCY, 1, cycles from rd to rvalid, 1..4.
- ID_VALUE, 32'h0001_0000, constant returned by the ID register, zero-extended to DATA_WIDTH.
- CTRL_RESET, 0, reset value of every control register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd  in  1  read strobe, one cycle per access
- raddr  in  ADDR_WIDTH  read byte address
- rdata  out  DATA_WIDTH  read data, valid with rvalid
- rvalid  out  1  read data valid, one-cycle pulse
- wr  in  1  write strobe, one cycle per access
- waddr  in  ADDR_WIDTH  write byte address
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  byte enables
- ctrl_q  out  NUM_CTRL*DATA_WIDTH  flattened control registers; word i at [i*DATA_WIDTH +: DATA_WIDTH]
- stat_evt  in  NUM_STAT  event pulses, one per status bit
- irq  out  1  level interrupt

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Address decode:
  - word index = addr >> log2(STRB_WIDTH); low address bits are ignored.
  - Index 0..NUM_CTRL-1 selects CTRL[i], RW.
  - Index NUM_CTRL selects STATUS, W1C.
  - Index NUM_CTRL+1 selects IRQ_EN, RW, low NUM_STAT bits only.
  - Index NUM_CTRL+2 selects ID, RO.
  - Any other index is unmapped.
- Writes:
  - Take effect on the clk edge where wr=1.
  - Each byte is updated only where wstrb is set.
  - Writes to ID and to unmapped addresses are silently dropped.
  - Bits of STATUS and IRQ_EN at or above NUM_STAT are read as 0 and ignore writes.
- STATUS register:
  - Bit n sets on the cycle after stat_evt[n]=1.
  - Bit n clears when written with 1 under an enabled strobe byte; writing 0 has no effect.
  - Simultaneous event and W1C on the same bit: the set wins and the bit stays 1.
- irq:
  - Registered; irq = |(STATUS & IRQ_EN), updated one cycle after either register changes.
  - A write to IRQ_EN or STATUS is therefore reflected on irq 2 cycles after the wr edge.
- Reads:
  - Address and decode are captured on rd.
  - Data is sampled from register state before any same-cycle write (read-before-write).
  - Data passes through a RD_LATENCY-stage pipeline; rvalid pulses exactly RD_LATENCY cycles after rd, with matching rdata.
  - Back-to-back rd on consecutive cycles is supported; each read gets its own rvalid.
  - Unmapped reads return 0.
  - rdata holds its last value while rvalid=0.
- Simultaneous rd and wr to different addresses: both complete independently.
- Reset values:
  - CTRL = CTRL_RESET; STATUS = 0; IRQ_EN = 0.
  - rdata = 0; rvalid = 0; irq = 0.
  - The read pipeline is flushed, so a read in flight when rst asserts produces no rvalid.
- No backpressure: the block always accepts rd/wr.

Optional Feature:
- Macro: AXI_CONFIG_REGFILE_CLR_ON_READ_EN.
- When defined:
  - STATUS is clear-on-read. The bits returned by a read are cleared on the cycle after rd.
  - An event arriving in the same cycle as the clear is kept.
  - Writes to STATUS are ignored.
- When undefined: STATUS is W1C as described above and reads have no side effects.

Test Plan:
- Reset, then read indices 0..NUM_CTRL+3 with RD_LATENCY=1 -> CTRL words read 0, ID reads 32'h0001_0000, index NUM_CTRL+3 reads 0, each rvalid exactly 1 cycle after rd.
- Write CTRL[2]=32'hAABBCCDD with wstrb=4'b1111, then 32'h11223344 with wstrb=4'b0101 -> ctrl_q word 2 = 32'hAA22CC44; readback matches; ID write leaves 32'h0001_0000.
- Pulse stat_evt[3] with IRQ_EN=0 -> STATUS=32'h8 and irq=0; write IRQ_EN=32'h8 -> irq=1 two cycles later; write STATUS=32'h8 -> STATUS=0 and irq falls.
- Assert stat_evt[5] in the same cycle as a W1C write of 32'h20 -> STATUS bit 5 remains 1.
- RD_LATENCY=3: rd on 4 consecutive cycles to CTRL[0..3] -> 4 rvalid pulses on cycles +3..+6 with in-order data; assert rst at cycle +2 -> no rvalid follows.
- With AXI_CONFIG_REGFILE_CLR_ON_READ_EN: set bits 0 and 1, read STATUS -> returns 32'h3, next read returns 0; W1C write has no effect.
